// File: rtl/segre_pkg.sv
`default_nettype none
// ============================================================================
// Module      : segre_pkg
// Description : Shared types and constants for the segre memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package segre_pkg;

    localparam int MEM_LINE_SIZE     = 128;
    localparam int DEFAULT_NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/segre_arb_picker.sv
`default_nettype none
// ============================================================================
// Module      : segre_arb_picker
// Description : Combinational rotating priority encoder; scans requests
//               starting at i_start, returns one-hot winner and its index.
// Revision    : 1.0 - initial release
// ============================================================================
module segre_arb_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_start,
    output logic [NUM_PORTS-1:0] o_onehot,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_valid
);

    int               w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_sum    = 0;
        w_pos    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // Position k steps after the start, wrapped into the port range.
            w_sum = int'(i_start) + k;
            if (w_sum >= NUM_PORTS) begin
                w_sum = w_sum - NUM_PORTS;
            end
            w_pos = IDX_W'(w_sum);
            if (!o_valid && i_req[w_pos]) begin
                o_valid         = 1'b1;
                o_idx           = w_pos;
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/segre_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : segre_mem_arbiter
// Description : N-port line arbiter in front of a single main-memory port.
//               Define SEGRE_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//               otherwise fixed priority, lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = MEM_LINE_SIZE
) (
    input  logic                                clk_i,
    input  logic                                rsn_i,
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0]                we_i,
    input  logic [NUM_PORTS-1:0][ADDR_SIZE-1:0] addr_i,
    input  logic [NUM_PORTS-1:0][LINE_SIZE-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]                gnt_o,
    output logic [NUM_PORTS-1:0]                rvalid_o,
    output logic [LINE_SIZE-1:0]                rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [ADDR_SIZE-1:0]                mem_addr_o,
    output logic [LINE_SIZE-1:0]                mem_wdata_o,
    input  logic                                mem_ack_i,
    input  logic [LINE_SIZE-1:0]                mem_rdata_i,
    output logic                                busy_o
);

    localparam int c_IDX_W = $clog2(NUM_PORTS);

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic [c_IDX_W-1:0]   w_start;
    logic [c_IDX_W-1:0]   w_win_idx;
    logic [NUM_PORTS-1:0] w_win_oh;
    logic                 w_win_valid;
    logic                 w_accept;
    logic [NUM_PORTS-1:0] r_owner_oh;
    logic                 r_gnt;
    logic                 r_we;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [LINE_SIZE-1:0] r_wdata;
    logic [LINE_SIZE-1:0] r_rdata;

    assign w_accept = (r_state == IDLE) && w_win_valid;

`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    logic [c_IDX_W-1:0] r_last;

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            r_last <= c_IDX_W'(NUM_PORTS - 1);
        end else if (w_accept) begin
            r_last <= w_win_idx;
        end
    end

    assign w_start = (int'(r_last) == NUM_PORTS - 1) ? '0 : r_last + 1'b1;
`else
    assign w_start = '0;
`endif

    segre_arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (c_IDX_W)
    ) u_picker (
        .i_req    (req_i),
        .i_start  (w_start),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_win_valid) w_state_next = BUSY;
            BUSY:    if (mem_ack_i)   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request is captured once at acceptance so mem_* stay stable in BUSY.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            r_gnt      <= 1'b0;
            r_owner_oh <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_gnt <= w_accept;
            if (w_accept) begin
                r_owner_oh <= w_win_oh;
                r_we       <= we_i[w_win_idx];
                r_addr     <= addr_i[w_win_idx];
                r_wdata    <= wdata_i[w_win_idx];
            end
            if ((r_state == BUSY) && mem_ack_i) begin
                r_rdata <= mem_rdata_i;
            end
        end
    end

    always_comb begin
        gnt_o     = r_gnt ? r_owner_oh : '0;
        rvalid_o  = (r_state == RESP) ? r_owner_oh : '0;
        mem_req_o = (r_state == BUSY);
        busy_o    = (r_state != IDLE);
    end

    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign rdata_o     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_segre_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_segre_mem_arbiter
// Description : Directed self-checking bench for segre_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segre_mem_arbiter;

`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    localparam int NP = 4;
`else
    localparam int NP = 2;
`endif
    localparam int AW = 32;
    localparam int LW = 128;

    logic                  clk_i = 1'b0;
    logic                  rsn_i;
    logic [NP-1:0]         req_i;
    logic [NP-1:0]         we_i;
    logic [NP-1:0][AW-1:0] addr_i;
    logic [NP-1:0][LW-1:0] wdata_i;
    logic [NP-1:0]         gnt_o;
    logic [NP-1:0]         rvalid_o;
    logic [LW-1:0]         rdata_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [AW-1:0]         mem_addr_o;
    logic [LW-1:0]         mem_wdata_o;
    logic                  mem_ack_i;
    logic [LW-1:0]         mem_rdata_i;
    logic                  busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    segre_mem_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_SIZE (AW),
        .LINE_SIZE (LW)
    ) dut (
        .clk_i       (clk_i),
        .rsn_i       (rsn_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rsn_i     = 1'b1;
        req_i     = '0;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rsn_i = 1'b0;
    endtask

    // Waits (bounded) for a grant and checks the captured memory request.
    task automatic wait_gnt(input int port, input logic we, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wdata, input bit drop);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (gnt_o == '0 && n < 10);
        check("gnt", gnt_o, NP'(1) << port);
        check("gnt_no_rvalid", rvalid_o, 0);
        check("mem_req", mem_req_o, 1);
        check("mem_we", mem_we_o, we);
        check("mem_addr", mem_addr_o, addr);
        check("mem_wdata", mem_wdata_o, wdata);
        if (drop) req_i[port] = 1'b0;
    endtask

    // Holds off ack for ack_wait cycles, then checks the response and the return to idle.
    task automatic finish_txn(input int port, input logic we, input logic [AW-1:0] addr,
                              input logic [LW-1:0] wdata, input int ack_wait,
                              input logic [LW-1:0] rdata);
        for (int k = 1; k <= ack_wait; k++) begin
            @(negedge clk_i);
            check("hold_req", mem_req_o, 1);
            check("hold_we", mem_we_o, we);
            check("hold_addr", mem_addr_o, addr);
            check("hold_wdata", mem_wdata_o, wdata);
            check("hold_no_gnt", gnt_o, 0);
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        check("rvalid", rvalid_o, NP'(1) << port);
        check("resp_no_gnt", gnt_o, 0);
        check("resp_busy", busy_o, 1);
        check("resp_no_req", mem_req_o, 0);
        if (!we) check("rdata", rdata_o, rdata);
        @(negedge clk_i);
        check("idle_rvalid", rvalid_o, 0);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rsn_i       = 1'b1;
        req_i       = '0;
        we_i        = '0;
        addr_i      = '0;
        wdata_i     = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;

        do_reset();
        check("rst_gnt", gnt_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_busy", busy_o, 0);

        // Single read from port 0, ack three cycles after mem_req.
        addr_i[0] = 32'h100;
        req_i[0]  = 1'b1;
        wait_gnt(0, 1'b0, 32'h100, '0, 1'b1);
        finish_txn(0, 1'b0, 32'h100, '0, 3, {16{8'hA5}});

        // Write from port 1.
        we_i[1]    = 1'b1;
        addr_i[1]  = 32'h40;
        wdata_i[1] = 128'h1234;
        req_i[1]   = 1'b1;
        wait_gnt(1, 1'b1, 32'h40, 128'h1234, 1'b1);
        finish_txn(1, 1'b1, 32'h40, 128'h1234, 2, 128'hDEAD);
        we_i[1]    = 1'b0;
        wdata_i[1] = '0;

`ifdef SEGRE_ARB_ROUND_ROBIN_EN
        // All four ports request continuously; grants must rotate.
        do_reset();
        for (int p = 0; p < NP; p++) addr_i[p] = AW'(32'h1000 + p * 16);
        req_i = '1;
        for (int i = 0; i < 8; i++) begin
            wait_gnt(i % 4, 1'b0, AW'(32'h1000 + (i % 4) * 16), '0, 1'b0);
            finish_txn(i % 4, 1'b0, AW'(32'h1000 + (i % 4) * 16), '0, 0, LW'(i + 1));
        end
        req_i = '0;
`else
        // Simultaneous requests; lowest index first, port 1 keeps holding.
        addr_i[0] = 32'h200;
        addr_i[1] = 32'h300;
        req_i     = 2'b11;
        wait_gnt(0, 1'b0, 32'h200, '0, 1'b1);
        finish_txn(0, 1'b0, 32'h200, '0, 0, 128'h1111);
        wait_gnt(1, 1'b0, 32'h300, '0, 1'b1);
        finish_txn(1, 1'b0, 32'h300, '0, 1, 128'h2222);
`endif

        // Reset while waiting for ack; late ack must not produce rvalid.
        do_reset();
        addr_i[0] = 32'h500;
        req_i[0]  = 1'b1;
        wait_gnt(0, 1'b0, 32'h500, '0, 1'b1);
        @(negedge clk_i);
        rsn_i = 1'b1;
        @(negedge clk_i);
        check("abort_mem_req", mem_req_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_rvalid", rvalid_o, 0);
        check("abort_mem_addr", mem_addr_o, 0);
        rsn_i       = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = {16{8'h5A}};
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        check("late_ack_rvalid", rvalid_o, 0);
        check("late_ack_busy", busy_o, 0);
        check("late_ack_gnt", gnt_o, 0);
        @(negedge clk_i);
        check("late_ack_rvalid2", rvalid_o, 0);
        check("late_ack_rdata", rdata_o, 0);

        // Spurious ack in IDLE.
        mem_ack_i   = 1'b1;
        mem_rdata_i = '1;
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        check("spur_busy", busy_o, 0);
        check("spur_rvalid", rvalid_o, 0);
        check("spur_gnt", gnt_o, 0);
        check("spur_rdata", rdata_o, 0);

        // Port 1 pulses a request during port 0's transaction and withdraws.
        addr_i[0] = 32'h600;
        addr_i[1] = 32'h700;
        req_i[0]  = 1'b1;
        wait_gnt(0, 1'b0, 32'h600, '0, 1'b1);
        req_i[1] = 1'b1;
        @(negedge clk_i);
        req_i[1] = 1'b0;
        check("wd_no_gnt", gnt_o, 0);
        finish_txn(0, 1'b0, 32'h600, '0, 1, 128'hCAFE);
        @(negedge clk_i);
        check("wd_after_gnt", gnt_o, 0);
        check("wd_after_busy", busy_o, 0);
        @(negedge clk_i);
        check("wd_after_gnt2", gnt_o, 0);
        check("wd_after_req", mem_req_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
